// File: rtl/psw_flag_unit.sv
// psw_flag_unit
// Processor status word downstream of the H4 ALU stage. Holds C/V/Z/N/IE,
// loads from the ALU flags or the S-bus, keeps a 2-deep shadow stack for
// interrupt entry/return, and registers a branch-condition result for the
// sequencer.
//
// PSW bit map: [0] C, [1] V, [2] Z, [3] N, [4] IE, [15:5] read as zero.

module psw_flag_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ALU_result_bus,
   input  logic        carry,
   input  logic        overflow,
   input  logic        LPSW_ALU,
   input  logic        LPSW_S,
   input  logic [15:0] S_bus_in,
   input  logic        SPSW,
   input  logic        int_entry,
   input  logic        int_return,
   input  logic        cond_valid,
   input  logic [3:0]  cond,
   output logic [15:0] PSW_out,
   output logic [15:0] PSW,
   output logic        cond_true,
   output logic        cond_ready,
   output logic        stack_err
);

   localparam int        PSW_W   = 5;
   localparam int        C_BIT   = 0;
   localparam int        V_BIT   = 1;
   localparam int        Z_BIT   = 2;
   localparam int        N_BIT   = 3;
   localparam int        IE_BIT  = 4;
   localparam logic [1:0] SP_FULL = 2'(DEPTH);

   // Architectural state
   logic [PSW_W-1:0] r_psw;
   logic [1:0]       r_sp;
   logic [PSW_W-1:0] r_stack [0:DEPTH-1];
   logic             r_cond_true;
   logic             r_cond_ready;
   logic             r_stack_err;

   // Next-state and decode wires
   logic [PSW_W-1:0] w_psw_nxt;
   logic [1:0]       w_sp_nxt;
   logic [1:0]       w_sp_dec;
   logic             w_push;
   logic             w_err_set;
   logic             w_cond_eval;
   logic             w_alu_zero;
   logic [PSW_W-1:0] w_alu_flags;
   logic [PSW_W-1:0] w_pop_data;

   // Upper S-bus bits are architecturally ignored; collected here so the
   // intent is explicit.
   logic             w_unused_sbus;
   assign w_unused_sbus = &{1'b0, S_bus_in[15:PSW_W]};

   // Branch condition decode, always on the pre-update flags
   function automatic logic eval_cond(input logic [3:0] sel,
                                      input logic [PSW_W-1:0] flags);
      logic c, v, z, n;
      logic res;
      c = flags[C_BIT];
      v = flags[V_BIT];
      z = flags[Z_BIT];
      n = flags[N_BIT];
      case (sel)
         4'd0:    res = 1'b1;
         4'd1:    res = z;
         4'd2:    res = ~z;
         4'd3:    res = c;
         4'd4:    res = ~c;
         4'd5:    res = n;
         4'd6:    res = ~n;
         4'd7:    res = v;
         4'd8:    res = ~v;
         4'd9:    res = n ^ v;
         4'd10:   res = ~(n ^ v);
         4'd11:   res = z | (n ^ v);
         4'd12:   res = c & ~z;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Flag image built from the current ALU outputs; IE is carried over
   assign w_alu_zero  = (ALU_result_bus == 16'h0000);
   assign w_alu_flags = {r_psw[IE_BIT], ALU_result_bus[15], w_alu_zero,
                         overflow, carry};

   // Pop reads the entry just below the current stack pointer
   assign w_sp_dec   = r_sp - 2'd1;
   assign w_pop_data = r_stack[w_sp_dec[0]];

   assign w_cond_eval = eval_cond(cond, r_psw);

   // Prioritised control decode: return > entry > S-bus load > ALU update
   always_comb begin
      w_psw_nxt = r_psw;
      w_sp_nxt  = r_sp;
      w_push    = 1'b0;
      w_err_set = 1'b0;
      if (int_return) begin
         if (r_sp != 2'd0) begin
            w_sp_nxt  = w_sp_dec;
            w_psw_nxt = w_pop_data;
         end else begin
            w_err_set = 1'b1;
         end
      end else if (int_entry) begin
         if (r_sp < SP_FULL) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + 2'd1;
         end else begin
            w_err_set = 1'b1;
         end
         // IE drops on entry even when the push overflowed
         w_psw_nxt[IE_BIT] = 1'b0;
      end else if (LPSW_S) begin
         w_psw_nxt = S_bus_in[PSW_W-1:0];
      end else if (LPSW_ALU) begin
         w_psw_nxt = w_alu_flags;
      end
   end

   // PSW register and stack pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_psw <= '0;
         r_sp  <= 2'd0;
      end else begin
         r_psw <= w_psw_nxt;
         r_sp  <= w_sp_nxt;
      end
   end

   // Shadow stack storage; entries survive a pop and clear only on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stack[i] <= '0;
         end
      end else if (w_push) begin
         r_stack[r_sp[0]] <= r_psw;
      end
   end

   // Sticky stack overflow/underflow indicator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stack_err <= 1'b0;
      end else if (w_err_set) begin
         r_stack_err <= 1'b1;
      end
   end

   // Registered condition result with a one-cycle ready pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cond_true  <= 1'b0;
         r_cond_ready <= 1'b0;
      end else begin
         r_cond_ready <= cond_valid;
         if (cond_valid) begin
            r_cond_true <= w_cond_eval;
         end
      end
   end

   assign PSW        = {{(16-PSW_W){1'b0}}, r_psw};
   assign PSW_out    = PSW & {16{SPSW}};
   assign cond_true  = r_cond_true;
   assign cond_ready = r_cond_ready;
   assign stack_err  = r_stack_err;

endmodule
